// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO arbiter: parameter defaults, requester
// indices for the round-robin ring and the controller state encoding.
package fifo_ctrl_pkg;

  localparam int DW_DEF     = 32;
  localparam int DEPTH_DEF  = 16;
  localparam int RD_LAT_DEF = 1;

  // Positions on the arbitration ring wr0 -> wr1 -> rd -> wr0.
  typedef enum logic [1:0] {
    REQ_WR0 = 2'd0,
    REQ_WR1 = 2'd1,
    REQ_RD  = 2'd2
  } req_idx_e;

  // RUN: normal service. DRAIN: writes blocked until the FIFO is empty and
  // every granted read has produced its rd_valid.
  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fifo_state_e;

  // Ring successor of a requester; used to move the priority pointer.
  function automatic req_idx_e next_idx(input req_idx_e cur);
    req_idx_e nxt;
    case (cur)
      REQ_WR0: nxt = REQ_WR1;
      REQ_WR1: nxt = REQ_RD;
      default: nxt = REQ_WR0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fifo_arbiter_if.sv
// Client-side bundle of the FIFO arbiter: two producers and one consumer.
//
// Handshake: a requester raises its req bit and holds it (with stable data)
// until it sees its grant. Grants are combinational in the same cycle; the
// transfer is accepted in exactly the cycle where req && gnt are both high.
// rd_valid/rd_data return the read data later and carry no back-pressure.
interface fifo_arbiter_if #(
  parameter int DW = fifo_ctrl_pkg::DW_DEF
);

  logic [1:0]    wr_req;
  logic [DW-1:0] wr_data0;
  logic [DW-1:0] wr_data1;
  logic [1:0]    wr_gnt;
  logic          rd_req;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;

  // Producers/consumer side.
  modport master (
    output wr_req, wr_data0, wr_data1, rd_req,
    input  wr_gnt, rd_gnt, rd_valid, rd_data
  );

  // Arbiter side.
  modport slave (
    input  wr_req, wr_data0, wr_data1, rd_req,
    output wr_gnt, rd_gnt, rd_valid, rd_data
  );

endinterface

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter. Requests are masked by eligibility, the
// search starts at the priority pointer, and after any grant the pointer
// moves to the ring successor of the winner.
module rr_arb3
  import fifo_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,    // bit index = req_idx_e
  input  logic [2:0] elig,   // requester may be served this cycle
  output logic [2:0] gnt     // one-hot or zero
);

  req_idx_e   prio;
  logic [2:0] cand;

  assign cand = req & elig;

  // Pick the first eligible requester walking the ring from the pointer.
  always_comb begin
    gnt = 3'b000;
    case (prio)
      REQ_WR0: begin
        if (cand[0])      gnt = 3'b001;
        else if (cand[1]) gnt = 3'b010;
        else if (cand[2]) gnt = 3'b100;
      end
      REQ_WR1: begin
        if (cand[1])      gnt = 3'b010;
        else if (cand[2]) gnt = 3'b100;
        else if (cand[0]) gnt = 3'b001;
      end
      default: begin
        if (cand[2])      gnt = 3'b100;
        else if (cand[0]) gnt = 3'b001;
        else if (cand[1]) gnt = 3'b010;
      end
    endcase
  end

  // Advance the pointer past the winner; hold it when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= REQ_WR0;
    end else if (gnt[0]) begin
      prio <= next_idx(REQ_WR0);
    end else if (gnt[1]) begin
      prio <= next_idx(REQ_WR1);
    end else if (gnt[2]) begin
      prio <= next_idx(REQ_RD);
    end
  end

endmodule

// File: rtl/fifo_arbiter.sv
// FIFO front-end arbiter: shares one FIFO command port between two writers
// and one reader, tracks occupancy, returns read data after the FIFO read
// latency and supports a drain request that blocks writes until empty.
module fifo_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  fifo_arbiter_if.slave              bus,
  input  logic                       drain,
  output logic                       drain_done,
  output logic                       fifo_en,
  output logic                       fifo_wr_rd,
  output logic [DW-1:0]              fifo_datain,
  input  logic [DW-1:0]              fifo_dataout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output fifo_state_e                state_dbg
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = RD_LAT + 1;
  // Pipeline stage that drives rd_valid.
  localparam logic [PW-1:0] VALID_BIT = PW'(1) << RD_LAT;

  fifo_state_e   state_q;
  logic [CW-1:0] count_q;
  logic [2:0]    req;
  logic [2:0]    elig;
  logic [2:0]    gnt;
  logic          wr_ok;
  logic          rd_ok;
  logic [PW-1:0] rd_pipe;
  logic          rd_pending;
  logic          drain_idle;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Writes stop while full or draining; the drain pulse itself already
  // blocks writes so nothing slips in during the cycle it arrives.
  assign wr_ok = rst_n && !full && (state_q == RUN) && !drain;
  assign rd_ok = rst_n && !empty;

  assign req  = {bus.rd_req, bus.wr_req};
  assign elig = {rd_ok, wr_ok, wr_ok};

  rr_arb3 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .elig  (elig),
    .gnt   (gnt)
  );

  assign bus.wr_gnt = gnt[1:0];
  assign bus.rd_gnt = gnt[2];

  // Register the granted command toward the FIFO; data/direction hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_en     <= 1'b0;
      fifo_wr_rd  <= 1'b0;
      fifo_datain <= '0;
    end else begin
      fifo_en <= |gnt;
      if (gnt[0]) begin
        fifo_wr_rd  <= 1'b1;
        fifo_datain <= bus.wr_data0;
      end else if (gnt[1]) begin
        fifo_wr_rd  <= 1'b1;
        fifo_datain <= bus.wr_data1;
      end else if (gnt[2]) begin
        fifo_wr_rd  <= 1'b0;
      end
    end
  end

  // Occupancy follows the grant so eligibility is exact in the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (gnt[0] || gnt[1]) begin
      count_q <= count_q + CW'(1);
    end else if (gnt[2]) begin
      count_q <= count_q - CW'(1);
    end
  end

  // Read-return shift register: stage 0 is the command cycle, the top stage
  // is the data-valid cycle RD_LAT cycles later. Reset drops in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe <= (rd_pipe << 1) | PW'(gnt[2]);
    end
  end

  assign bus.rd_valid = rd_pipe[RD_LAT];
  assign bus.rd_data  = fifo_dataout;

  // A read is pending until the cycle its rd_valid is shown.
  assign rd_pending = (|(rd_pipe & ~VALID_BIT)) || gnt[2];
  assign drain_idle = (count_q == '0) && !rd_pending;

  // Drain controller; drain_done is a registered one-cycle pulse that lands
  // together with the return to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      case (state_q)
        RUN: begin
          if (drain) begin
            if (drain_idle) begin
              drain_done <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_idle) begin
            state_q    <= RUN;
            drain_done <= 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
`timescale 1ns/1ps
module tb_fifo_arbiter;
  import fifo_ctrl_pkg::*;

  localparam int DW     = 32;
  localparam int DEPTH  = 16;
  localparam int RD_LAT = 1;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int AW     = $clog2(DEPTH);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_arbiter_if #(.DW(DW)) bus ();

  logic          drain;
  logic          drain_done;
  logic          fifo_en;
  logic          fifo_wr_rd;
  logic [DW-1:0] fifo_datain;
  logic [DW-1:0] fifo_dataout;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  fifo_state_e   state_dbg;

  fifo_arbiter #(.DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .drain        (drain),
    .drain_done   (drain_done),
    .fifo_en      (fifo_en),
    .fifo_wr_rd   (fifo_wr_rd),
    .fifo_datain  (fifo_datain),
    .fifo_dataout (fifo_dataout),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .state_dbg    (state_dbg)
  );

  // Behavioural FIFO storage with one cycle of read latency.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp           <= '0;
      rp           <= '0;
      fifo_dataout <= '0;
    end else if (fifo_en) begin
      if (fifo_wr_rd) begin
        mem[wp] <= fifo_datain;
        wp      <= wp + 1'b1;
      end else begin
        fifo_dataout <= mem[rp];
        rp           <= rp + 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests;
  int n_fail;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Read data is compared against the order writes were expected to be granted.
  always @(negedge clk) begin
    #3;
    if (rst_n) begin
      check("grant_onehot", 32'($onehot0({bus.rd_gnt, bus.wr_gnt})), 32'd1);
      if (bus.rd_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rd_valid: got unexpected pulse, required none (data 0x%0h) at %0t",
                   bus.rd_data, $time);
        end else begin
          exp_v = exp_q.pop_front();
          check("rd_data", 32'(bus.rd_data), 32'(exp_v));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [1:0] wr, input logic rd, input logic dr,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    @(negedge clk);
    bus.wr_req   = wr;
    bus.rd_req   = rd;
    drain        = dr;
    bus.wr_data0 = d0;
    bus.wr_data1 = d1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_grants(input string tag, input logic [1:0] wg, input logic rg,
                            input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    check({tag, " wr_gnt"}, 32'(bus.wr_gnt), 32'(wg));
    check({tag, " rd_gnt"}, 32'(bus.rd_gnt), 32'(rg));
    if (wg[0]) exp_q.push_back(d0);
    if (wg[1]) exp_q.push_back(d1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    drain      = 1'b0;
    bus.wr_req = 2'b00;
    bus.rd_req = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [1:0]    wr_req;
    logic          rd_req;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [1:0]    wr_gnt;
    logic          rd_gnt;
    logic          en;
    logic          wr_rd;
    logic [DW-1:0] datain;
    logic [CW-1:0] cnt;
    logic          rv;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];
  vec_t v;

  function automatic vec_t mk(int wr, int rd, int d0, int d1, int wg, int rg,
                              int en, int wrd, int din, int cnt, int rv);
    vec_t r;
    r.wr_req = 2'(wr);
    r.rd_req = 1'(rd);
    r.d0     = DW'(d0);
    r.d1     = DW'(d1);
    r.wr_gnt = 2'(wg);
    r.rd_gnt = 1'(rg);
    r.en     = 1'(en);
    r.wr_rd  = 1'(wrd);
    r.datain = DW'(din);
    r.cnt    = CW'(cnt);
    r.rv     = 1'(rv);
    return r;
  endfunction

  initial begin
    // Columns: wr_req rd_req d0 d1 | wr_gnt rd_gnt | next cycle: en wr_rd datain count rd_valid
    vecs[0]  = mk(3, 0, 10,   20,   1, 0, 1, 1, 10,   1, 0);
    vecs[1]  = mk(3, 0, 10,   20,   2, 0, 1, 1, 20,   2, 0);
    vecs[2]  = mk(0, 1, 10,   20,   0, 1, 1, 0, 20,   1, 0);
    vecs[3]  = mk(0, 1, 10,   20,   0, 1, 1, 0, 20,   0, 1);
    vecs[4]  = mk(0, 0, 10,   20,   0, 0, 0, 0, 20,   0, 1);
    vecs[5]  = mk(0, 0, 10,   20,   0, 0, 0, 0, 20,   0, 0);
    vecs[6]  = mk(3, 0, 'h30, 'h40, 1, 0, 1, 1, 'h30, 1, 0);
    vecs[7]  = mk(3, 0, 'h30, 'h40, 2, 0, 1, 1, 'h40, 2, 0);
    vecs[8]  = mk(3, 0, 'h30, 'h40, 1, 0, 1, 1, 'h30, 3, 0);
    vecs[9]  = mk(3, 0, 'h30, 'h40, 2, 0, 1, 1, 'h40, 4, 0);
    vecs[10] = mk(3, 0, 'h30, 'h40, 1, 0, 1, 1, 'h30, 5, 0);
    vecs[11] = mk(0, 1, 'h30, 'h40, 0, 1, 1, 0, 'h30, 4, 0);
    vecs[12] = mk(3, 1, 'h50, 'h60, 1, 0, 1, 1, 'h50, 5, 1);
    vecs[13] = mk(3, 1, 'h50, 'h60, 2, 0, 1, 1, 'h60, 6, 0);
    vecs[14] = mk(3, 1, 'h50, 'h60, 0, 1, 1, 0, 'h60, 5, 0);
    vecs[15] = mk(3, 1, 'h50, 'h60, 1, 0, 1, 1, 'h50, 6, 1);
    vecs[16] = mk(0, 0, 'h50, 'h60, 0, 0, 0, 1, 'h50, 6, 0);
  end

  // ---------------- test sequence ----------------
  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    drain        = 1'b0;
    bus.wr_req   = 2'b11;
    bus.rd_req   = 1'b1;
    bus.wr_data0 = 32'hdead;
    bus.wr_data1 = 32'hbeef;

    // Reset values, with requests active to show grants are suppressed.
    repeat (2) @(posedge clk);
    #1;
    check("rst wr_gnt",     32'(bus.wr_gnt),   32'd0);
    check("rst rd_gnt",     32'(bus.rd_gnt),   32'd0);
    check("rst fifo_en",    32'(fifo_en),      32'd0);
    check("rst fifo_wr_rd", 32'(fifo_wr_rd),   32'd0);
    check("rst datain",     32'(fifo_datain),  32'd0);
    check("rst rd_valid",   32'(bus.rd_valid), 32'd0);
    check("rst count",      32'(count),        32'd0);
    check("rst drain_done", 32'(drain_done),   32'd0);
    check("rst state",      32'(state_dbg),    32'(RUN));
    check("rst empty",      32'(empty),        32'd1);
    check("rst full",       32'(full),         32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    bus.wr_req = 2'b00;
    bus.rd_req = 1'b0;

    // Table: two-writer start, back-to-back reads, mixed round-robin at count 4.
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      drive(v.wr_req, v.rd_req, 1'b0, v.d0, v.d1);
      exp_grants($sformatf("vec%0d", i), v.wr_gnt, v.rd_gnt, v.d0, v.d1);
      tick();
      check($sformatf("vec%0d fifo_en", i),  32'(fifo_en),      32'(v.en));
      check($sformatf("vec%0d wr_rd", i),    32'(fifo_wr_rd),   32'(v.wr_rd));
      check($sformatf("vec%0d datain", i),   32'(fifo_datain),  32'(v.datain));
      check($sformatf("vec%0d count", i),    32'(count),        32'(v.cnt));
      check($sformatf("vec%0d rd_valid", i), 32'(bus.rd_valid), 32'(v.rv));
      check($sformatf("vec%0d empty", i),    32'(empty),        32'(v.cnt == '0));
    end

    // Fill from 6 to 16 with wr0 held.
    for (int i = 0; i < 10; i++) begin
      drive(2'b01, 1'b0, 1'b0, 32'(32'h100 + i), 32'h0);
      exp_grants("fill", 2'b01, 1'b0, 32'(32'h100 + i), 32'h0);
      tick();
      check("fill count", 32'(count), 32'(7 + i));
    end
    check("fill full", 32'(full), 32'd1);
    drive(2'b01, 1'b0, 1'b0, 32'h1ff, 32'h0);
    exp_grants("full_block", 2'b00, 1'b0, 32'h1ff, 32'h0);
    tick();
    check("full_block count", 32'(count),   32'd16);
    check("full_block en",    32'(fifo_en), 32'd0);
    drive(2'b01, 1'b1, 1'b0, 32'h1ff, 32'h0);
    exp_grants("full_rd", 2'b00, 1'b1, 32'h1ff, 32'h0);
    tick();
    check("full_rd count", 32'(count), 32'd15);
    check("full_rd full",  32'(full),  32'd0);
    drive(2'b01, 1'b0, 1'b0, 32'h1ff, 32'h0);
    exp_grants("refill", 2'b01, 1'b0, 32'h1ff, 32'h0);
    tick();
    check("refill count", 32'(count), 32'd16);
    check("refill full",  32'(full),  32'd1);
    drive(2'b01, 1'b0, 1'b0, 32'h1ff, 32'h0);
    exp_grants("full_again", 2'b00, 1'b0, 32'h1ff, 32'h0);
    tick();

    // Read down to 3 entries.
    for (int i = 0; i < 13; i++) begin
      drive(2'b00, 1'b1, 1'b0, 32'h0, 32'h0);
      exp_grants("rd_down", 2'b00, 1'b1, 32'h0, 32'h0);
      tick();
      check("rd_down count", 32'(count), 32'(15 - i));
    end

    // Drain at count 3 with wr0 requesting; a second drain pulse is ignored.
    drive(2'b01, 1'b1, 1'b1, 32'h77, 32'h0);
    exp_grants("drn0", 2'b00, 1'b1, 32'h77, 32'h0);
    tick();
    check("drn0 count", 32'(count),      32'd2);
    check("drn0 state", 32'(state_dbg),  32'(DRAIN));
    check("drn0 done",  32'(drain_done), 32'd0);
    drive(2'b01, 1'b1, 1'b0, 32'h77, 32'h0);
    exp_grants("drn1", 2'b00, 1'b1, 32'h77, 32'h0);
    tick();
    check("drn1 count", 32'(count), 32'd1);
    drive(2'b01, 1'b1, 1'b1, 32'h77, 32'h0);
    exp_grants("drn2", 2'b00, 1'b1, 32'h77, 32'h0);
    tick();
    check("drn2 count", 32'(count),     32'd0);
    check("drn2 state", 32'(state_dbg), 32'(DRAIN));
    drive(2'b01, 1'b0, 1'b0, 32'h77, 32'h0);
    exp_grants("drn3", 2'b00, 1'b0, 32'h77, 32'h0);
    tick();
    check("drn3 rd_valid", 32'(bus.rd_valid), 32'd1);
    check("drn3 done",     32'(drain_done),   32'd0);
    check("drn3 state",    32'(state_dbg),    32'(DRAIN));
    drive(2'b01, 1'b0, 1'b0, 32'h77, 32'h0);
    exp_grants("drn4", 2'b00, 1'b0, 32'h77, 32'h0);
    tick();
    check("drn4 done",     32'(drain_done),   32'd1);
    check("drn4 state",    32'(state_dbg),    32'(RUN));
    check("drn4 rd_valid", 32'(bus.rd_valid), 32'd0);
    drive(2'b01, 1'b0, 1'b0, 32'h77, 32'h0);
    exp_grants("drn5", 2'b01, 1'b0, 32'h77, 32'h0);
    tick();
    check("drn5 done",  32'(drain_done), 32'd0);
    check("drn5 count", 32'(count),      32'd1);

    // Drain when already empty and idle: done on the next cycle.
    apply_reset();
    drive(2'b00, 1'b0, 1'b1, 32'h0, 32'h0);
    tick();
    check("idle_drain done",  32'(drain_done), 32'd1);
    check("idle_drain state", 32'(state_dbg),  32'(RUN));
    drive(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("idle_drain done_off", 32'(drain_done), 32'd0);

    // Reset one cycle after a read grant discards the pending read.
    apply_reset();
    drive(2'b01, 1'b0, 1'b0, 32'h88, 32'h0);
    exp_grants("mid_wr", 2'b01, 1'b0, 32'h88, 32'h0);
    tick();
    check("mid_wr count", 32'(count), 32'd1);
    drive(2'b00, 1'b1, 1'b0, 32'h0, 32'h0);
    exp_grants("mid_rd", 2'b00, 1'b1, 32'h0, 32'h0);
    tick();
    bus.rd_req = 1'b0;
    rst_n      = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_rst rd_valid", 32'(bus.rd_valid), 32'd0);
      check("mid_rst count",    32'(count),        32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

endmodule
